// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// bus_pkg : shared bus constants, master indices and DMA state encodings
// Revision : 1.0
// ============================================================================
package bus_pkg;

  localparam int c_aw = 8;
  localparam int c_dw = 32;
  localparam int c_lw = 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_addr_cnt.sv
`default_nettype none
// ============================================================================
// dma_addr_cnt : source/destination word incrementers and length down-counter
// Revision : 1.0
// ============================================================================
module dma_addr_cnt
  import bus_pkg::*;
#(
  parameter int AW = c_aw,
  parameter int LW = c_lw
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic          i_advance,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [LW-1:0] i_len,
  output logic [AW-1:0] o_src,
  output logic [AW-1:0] o_dst,
  output logic          o_last
);

  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [LW-1:0] r_cnt;

  // Addresses wrap naturally at 2^AW
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_src <= i_src;
      r_dst <= i_dst;
      r_cnt <= i_len;
    end else if (i_advance) begin
      r_src <= r_src + AW'(1);
      r_dst <= r_dst + AW'(1);
      r_cnt <= r_cnt - LW'(1);
    end
  end

  assign o_src  = r_src;
  assign o_dst  = r_dst;
  assign o_last = (r_cnt == LW'(1));

endmodule
`default_nettype wire

// File: rtl/bus_dma_master.sv
`default_nettype none
// ============================================================================
// bus_dma_master : master-1 word copy engine; DMA_FILL_EN adds constant fill
// Revision : 1.0
// ============================================================================
module bus_dma_master
  import bus_pkg::*;
#(
  parameter int AW = c_aw,
  parameter int DW = c_dw,
  parameter int LW = c_lw
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic          m_req,
  input  logic          m_grant,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_dout,
  input  logic [DW-1:0] m_din,
`ifdef DMA_FILL_EN
  input  logic          fill_mode,
  input  logic [DW-1:0] fill_data,
`endif
  output logic          busy,
  output logic          done
);

  dma_state_t    r_state;
  logic [DW-1:0] r_data;
  logic          r_req;
  logic          r_busy;
  logic          r_done;
  logic          w_fill;
  logic          w_load;
  logic          w_advance;
  logic          w_last;
  logic          w_rd_cyc;
  logic          w_wr_cyc;
  logic [AW-1:0] w_src;
  logic [AW-1:0] w_dst;

`ifdef DMA_FILL_EN
  logic r_fill;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_fill <= 1'b0;
    else if (r_state == ST_IDLE && start) r_fill <= fill_mode;
  end
  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  assign w_load    = (r_state == ST_IDLE) && start;
  // Only a granted WR commits a word; aborted words leave the pointers alone
  assign w_advance = (r_state == ST_WR) && m_grant;

  dma_addr_cnt #(
    .AW(AW),
    .LW(LW)
  ) u_addr_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_advance(w_advance),
    .i_src    (src),
    .i_dst    (dst),
    .i_len    (len),
    .o_src    (w_src),
    .o_dst    (w_dst),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
`ifdef DMA_FILL_EN
            r_data <= fill_data;
`endif
            if (len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (m_grant) r_state <= w_fill ? ST_WR : ST_RD;
        end
        ST_RD: begin
          r_state <= m_grant ? ST_CAP : ST_REQ;
        end
        ST_CAP: begin
          if (m_grant) begin
            r_data  <= m_din;
            r_state <= ST_WR;
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_WR: begin
          if (!m_grant) begin
            r_state <= ST_REQ;
          end else if (w_last) begin
            r_state <= ST_DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= w_fill ? ST_WR : ST_RD;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Bus lines are idle-zero unless this master holds the grant in RD or WR
  assign w_rd_cyc = (r_state == ST_RD) && m_grant;
  assign w_wr_cyc = (r_state == ST_WR) && m_grant;

  assign m_req  = r_req;
  assign m_wr   = w_wr_cyc;
  assign m_addr = w_rd_cyc ? w_src : (w_wr_cyc ? w_dst : '0);
  assign m_dout = w_wr_cyc ? r_data : '0;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bus_dma_master.sv
`default_nettype none
// ============================================================================
// tb_bus_dma_master : directed checks of bus_dma_master against a bus/memory model
// Revision : 1.0
// ============================================================================
module tb_bus_dma_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  src;
  logic [7:0]  dst;
  logic [7:0]  len;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        busy;
  logic        done;
  logic        preempt;
`ifdef DMA_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_data;
`endif

  int n_cmp;
  int n_err;

  bus_dma_master #(.AW(8), .DW(32), .LW(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .m_req    (m_req),
    .m_grant  (m_grant),
    .m_wr     (m_wr),
    .m_addr   (m_addr),
    .m_dout   (m_dout),
    .m_din    (m_din),
`ifdef DMA_FILL_EN
    .fill_mode(fill_mode),
    .fill_data(fill_data),
`endif
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter stand-in: grant follows request unless master 0 takes the bus
  assign m_grant = m_req & ~preempt;

  // Unwritten locations read back a fixed pattern: 0x00..0x03 -> 0xA0..0xA3
  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'h0000_00A0 ^ {24'h0, a};
  endfunction

  logic [31:0] mem [256];
  bit          written [256];
  int          cyc;
  int          req_cnt;
  int          rd_nz_cnt;
  logic [7:0]  wr_addr_q [$];
  int          wr_cyc_q [$];

  function automatic logic [31:0] rd_mem(input logic [7:0] a);
    return written[a] ? mem[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    m_din <= rd_mem(m_addr);
    cyc = cyc + 1;
    if (m_req) req_cnt = req_cnt + 1;
    if (m_grant && !m_wr && m_addr != 8'h00) rd_nz_cnt = rd_nz_cnt + 1;
    if (m_wr) begin
      mem[m_addr]     = m_dout;
      written[m_addr] = 1'b1;
      wr_addr_q.push_back(m_addr);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle, then waits (bounded) for done.
  // lat = number of falling edges after the start cycle until done is seen.
  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int max_k, output int lat);
    src   = s;
    dst   = d;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= max_k; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat;
  int q0;
  int r0;

  initial begin
    n_cmp = 0; n_err = 0;
    cyc = 0; req_cnt = 0; rd_nz_cnt = 0;
    reset_n = 1'b0; start = 1'b0; preempt = 1'b0;
    src = '0; dst = '0; len = '0;
`ifdef DMA_FILL_EN
    fill_mode = 1'b0; fill_data = '0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_m_req",  {31'b0, m_req}, 32'd0);
    check_val("rst_m_wr",   {31'b0, m_wr},  32'd0);
    check_val("rst_busy",   {31'b0, busy},  32'd0);
    check_val("rst_done",   {31'b0, done},  32'd0);
    check_val("rst_m_addr", {24'b0, m_addr}, 32'd0);
    check_val("rst_m_dout", m_dout, 32'd0);

    // Uncontended copy 0x00..0x03 -> 0x20..0x23.
    // REQ at k=1, words at k=2..13 (3 cycles each), done at k=14.
    q0 = wr_addr_q.size();
    src = 8'h00; dst = 8'h20; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("copy_req_after_start", {31'b0, m_req}, 32'd1);
    check_val("copy_busy", {31'b0, busy}, 32'd1);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    check_val("copy_done_latency", 32'(lat), 32'd14);
    check_val("copy_req_at_done", {31'b0, m_req}, 32'd0);
    @(negedge clk);
    check_val("copy_done_one_cycle", {31'b0, done}, 32'd0);
    check_val("copy_busy_cleared", {31'b0, busy}, 32'd0);
    check_val("copy_wr_count", 32'(wr_addr_q.size() - q0), 32'd4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("copy_mem_%0d", i), rd_mem(8'h20 + 8'(i)), 32'hA0 + 32'(i));

    // Zero length: done the cycle after start, no bus request
    r0 = req_cnt;
    q0 = wr_addr_q.size();
    run_xfer(8'h00, 8'h28, 8'd0, 10, lat);
    check_val("zero_done_latency", 32'(lat), 32'd1);
    @(negedge clk);
    check_val("zero_req_cycles", 32'(req_cnt - r0), 32'd0);
    check_val("zero_wr_count", 32'(wr_addr_q.size() - q0), 32'd0);

    // Preemption: grant dropped during CAP of word 1 (k=6) for 5 cycles.
    // Word 1 restarts with RD at k=12; done at k=21.
    q0 = wr_addr_q.size();
    src = 8'h40; dst = 8'h50; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 6)  preempt = 1'b1;
      if (k == 11) preempt = 1'b0;
      if (k == 8) begin
        check_val("preempt_req_held", {31'b0, m_req}, 32'd1);
        check_val("preempt_bus_idle", {23'b0, m_wr, m_addr}, 32'd0);
      end
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    preempt = 1'b0;
    check_val("preempt_done_latency", 32'(lat), 32'd21);
    check_val("preempt_wr_count", 32'(wr_addr_q.size() - q0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (q0 + i < wr_addr_q.size())
        check_val($sformatf("preempt_wr_addr_%0d", i), {24'b0, wr_addr_q[q0+i]}, 32'h50 + 32'(i));
      check_val($sformatf("preempt_mem_%0d", i), rd_mem(8'h50 + 8'(i)), 32'hE0 + 32'(i));
    end
    @(negedge clk);

    // Address wrap: reads 0xFE, 0xFF, 0x00 (patterns 0x5E, 0x5F, 0xA0)
    run_xfer(8'hFE, 8'h30, 8'd3, 40, lat);
    check_val("wrap_done_latency", 32'(lat), 32'd11);
    check_val("wrap_mem_0", rd_mem(8'h30), 32'h5E);
    check_val("wrap_mem_1", rd_mem(8'h31), 32'h5F);
    check_val("wrap_mem_2", rd_mem(8'h32), 32'hA0);
    @(negedge clk);

    // Reset during WR of word 2 (k=10), between clock edges
    src = 8'h00; dst = 8'h60; len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_val("rstmid_in_wr", {23'b0, m_wr, m_addr}, {23'b0, 1'b1, 8'h62});
    #2 reset_n = 1'b0;
    #1;
    check_val("rstmid_outputs", {28'b0, m_req, m_wr, busy, done}, 32'd0);
    check_val("rstmid_addr", {24'b0, m_addr}, 32'd0);
    check_val("rstmid_dout", m_dout, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rstmid_word2_not_written", {31'b0, written[8'h62]}, 32'd0);
    check_val("rstmid_word1_written", rd_mem(8'h61), 32'hA1);
    run_xfer(8'h02, 8'h70, 8'd2, 40, lat);
    check_val("post_rst_done_latency", 32'(lat), 32'd8);
    check_val("post_rst_mem_0", rd_mem(8'h70), 32'hA2);
    check_val("post_rst_mem_1", rd_mem(8'h71), 32'hA3);
    @(negedge clk);

`ifdef DMA_FILL_EN
    // Fill: REQ at k=1, WR at k=2 and k=3, done at k=4, no reads
    q0 = wr_addr_q.size();
    r0 = rd_nz_cnt;
    fill_mode = 1'b1;
    fill_data = 32'hDEADBEEF;
    run_xfer(8'h05, 8'h10, 8'd2, 20, lat);
    fill_mode = 1'b0;
    check_val("fill_done_latency", 32'(lat), 32'd4);
    check_val("fill_wr_count", 32'(wr_addr_q.size() - q0), 32'd2);
    if (wr_addr_q.size() >= q0 + 2)
      check_val("fill_wr_consecutive", 32'(wr_cyc_q[q0+1] - wr_cyc_q[q0]), 32'd1);
    check_val("fill_no_reads", 32'(rd_nz_cnt - r0), 32'd0);
    check_val("fill_mem_0", rd_mem(8'h10), 32'hDEADBEEF);
    check_val("fill_mem_1", rd_mem(8'h11), 32'hDEADBEEF);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
